// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the core's execute stage and the RV32M multiply/divide unit.
// The core drives the master side; the unit implements the slave side.
interface muldiv_unit_if;
    logic        start;
    logic        flush;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  rd_in;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    modport master (
        output start, flush, funct3, op_a, op_b, rd_in,
        input  busy, done, result, rd_out
    );

    modport slave (
        input  start, flush, funct3, op_a, op_b, rd_in,
        output busy, done, result, rd_out
    );
endinterface

// File: rtl/muldiv_unit.sv
// RV32M execute unit: single-cycle multiply, 32-iteration restoring divide,
// start/busy/done handshake with a completion tag.
module muldiv_unit (
    input  logic          clk,
    input  logic          rst_n,
    muldiv_unit_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StExec, StDiv, StDone} state_e;

    state_e      state_q, state_d;
    logic [2:0]  fn_q, fn_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [4:0]  tag_q, tag_d;
    logic [32:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dvs_q, dvs_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        neg_q, neg_d;
    logic        sa_q, sa_d;
    logic [31:0] result_q, result_d;
    logic [4:0]  rd_out_q, rd_out_d;

    // Acceptance-time decode of the incoming request
    logic        accept;
    logic        in_signed;
    logic        in_sa, in_sb;
    logic        in_special;
    assign accept     = bus.start && !bus.flush && (state_q == StIdle || state_q == StDone);
    assign in_signed  = !bus.funct3[0];
    assign in_sa      = in_signed && bus.op_a[31];
    assign in_sb      = in_signed && bus.op_b[31];
    assign in_special = !bus.funct3[2] || (bus.op_b == 32'd0) ||
                        (in_signed && bus.op_a == 32'h8000_0000 && bus.op_b == 32'hFFFF_FFFF);

    // Multiplier: operands sign- or zero-extended to 33 bits according to funct3
    logic signed [32:0] mul_a, mul_b;
    logic signed [65:0] prod;
    assign mul_a = {!(fn_q[1] && fn_q[0]) && a_q[31], a_q};
    assign mul_b = {!fn_q[1] && b_q[31], b_q};
    assign prod  = mul_a * mul_b;

    logic [31:0] exec_res;
    always_comb begin
        exec_res = 32'd0;
        if (!fn_q[2]) begin
            exec_res = (fn_q[1:0] == 2'b00) ? prod[31:0] : prod[63:32];
        end else if (b_q == 32'd0) begin
            exec_res = fn_q[1] ? a_q : 32'hFFFF_FFFF;
        end else begin
            // Only signed overflow reaches here: DIV -> most-negative, REM -> 0
            exec_res = fn_q[1] ? 32'd0 : 32'h8000_0000;
        end
    end

    // One restoring step; the low dividend bits live in quo_q and shift out as quotient shifts in
    logic [32:0] rem_sh, diff, rem_next;
    logic        q_bit;
    logic [31:0] quo_next, q_fin, r_fin, div_res;
    assign rem_sh   = {rem_q[31:0], quo_q[31]};
    assign diff     = rem_sh - {1'b0, dvs_q};
    assign q_bit    = !diff[32];
    assign rem_next = q_bit ? diff : rem_sh;
    assign quo_next = {quo_q[30:0], q_bit};
    assign q_fin    = neg_q ? -quo_next : quo_next;
    assign r_fin    = sa_q ? -rem_next[31:0] : rem_next[31:0];
    assign div_res  = fn_q[1] ? r_fin : q_fin;

    always_comb begin
        state_d  = state_q;
        fn_d     = fn_q;
        a_d      = a_q;
        b_d      = b_q;
        tag_d    = tag_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        sa_d     = sa_q;
        result_d = result_q;
        rd_out_d = rd_out_q;

        if (bus.flush) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    state_d = StIdle;
                    if (accept) begin
                        fn_d  = bus.funct3;
                        a_d   = bus.op_a;
                        b_d   = bus.op_b;
                        tag_d = bus.rd_in;
                        if (in_special) begin
                            state_d = StExec;
                        end else begin
                            state_d = StDiv;
                            rem_d   = 33'd0;
                            quo_d   = in_sa ? -bus.op_a : bus.op_a;
                            dvs_d   = in_sb ? -bus.op_b : bus.op_b;
                            cnt_d   = 5'd0;
                            neg_d   = in_sa ^ in_sb;
                            sa_d    = in_sa;
                        end
                    end
                end
                StExec: begin
                    result_d = exec_res;
                    rd_out_d = tag_q;
                    state_d  = StDone;
                end
                StDiv: begin
                    rem_d = rem_next;
                    quo_d = quo_next;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        result_d = div_res;
                        rd_out_d = tag_q;
                        state_d  = StDone;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            fn_q     <= 3'd0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            tag_q    <= 5'd0;
            rem_q    <= 33'd0;
            quo_q    <= 32'd0;
            dvs_q    <= 32'd0;
            cnt_q    <= 5'd0;
            neg_q    <= 1'b0;
            sa_q     <= 1'b0;
            result_q <= 32'd0;
            rd_out_q <= 5'd0;
        end else begin
            state_q  <= state_d;
            fn_q     <= fn_d;
            a_q      <= a_d;
            b_q      <= b_d;
            tag_q    <= tag_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            sa_q     <= sa_d;
            result_q <= result_d;
            rd_out_q <= rd_out_d;
        end
    end

    assign bus.busy   = (state_q == StExec) || (state_q == StDiv);
    assign bus.done   = (state_q == StDone);
    assign bus.result = result_q;
    assign bus.rd_out = rd_out_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and randomized checks of muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;

    logic clk;
    logic rst_n;
    muldiv_unit_if bus ();

    muldiv_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: RV32M semantics from plain 64-bit and 32-bit integer arithmetic
    function automatic logic [31:0] model(input logic [2:0] fn, input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sa = longint'($signed(a));
        longint      sb = longint'($signed(b));
        longint      ua = longint'({32'd0, a});
        longint      ub = longint'({32'd0, b});
        logic [63:0] p;
        logic        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (fn)
            3'd0: begin p = 64'(sa * sb); return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = 64'(ua * ub); return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 :
                         32'($signed(a) / $signed(b));
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] fn, input logic [31:0] a,
                                     input logic [31:0] b);
        if (!fn[2] || b == 0) return 1;
        if (!fn[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 32;
    endfunction

    // Drive a request; returns #1 after the accept edge with inputs scrambled
    task automatic send(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag);
        bus.start  = 1'b1;
        bus.funct3 = fn;
        bus.op_a   = a;
        bus.op_b   = b;
        bus.rd_in  = tag;
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
        bus.funct3 = 3'($urandom);
        bus.op_a   = $urandom;
        bus.op_b   = $urandom;
        bus.rd_in  = 5'($urandom);
    endtask

    // Wait (bounded) for done; checks busy during the wait, latency, result and tag
    task automatic wait_done(input string name, input int exp_lat, input logic [31:0] exp_res,
                             input logic [4:0] exp_tag);
        int   lat = 0;
        logic seen = 1'b0;
        logic busy_ok = 1'b1;
        while (!seen && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.done) seen = 1'b1;
            else if (bus.busy !== 1'b1) busy_ok = 1'b0;
        end
        check({name, ".done_seen"}, 32'(seen), 32'd1);
        check({name, ".busy_held"}, 32'(busy_ok), 32'd1);
        check({name, ".latency"}, 32'(lat), 32'(exp_lat));
        check({name, ".busy_at_done"}, 32'(bus.busy), 32'd0);
        check({name, ".result"}, bus.result, exp_res);
        check({name, ".rd_out"}, 32'(bus.rd_out), 32'(exp_tag));
    endtask

    task automatic do_op(input string name, input logic [2:0] fn, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] tag, input logic [31:0] exp,
                         input int exp_lat);
        @(negedge clk);
        send(fn, a, b, tag);
        wait_done(name, exp_lat - 0, exp, tag);
    endtask

    logic [31:0] ra, rb, last_res;
    logic [2:0]  rf;
    logic [4:0]  rt;
    logic        flag;

    initial begin
        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.flush  = 1'b0;
        bus.funct3 = 3'd0;
        bus.op_a   = 32'd0;
        bus.op_b   = 32'd0;
        bus.rd_in  = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.busy", 32'(bus.busy), 32'd0);
        check("reset.done", 32'(bus.done), 32'd0);
        check("reset.result", bus.result, 32'd0);
        check("reset.rd_out", 32'(bus.rd_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op("mul",    3'd0, 32'd7,         32'hFFFF_FFFD, 5'd3,  32'hFFFF_FFEB, 1);
        do_op("mulh",   3'd1, 32'h8000_0000, 32'h8000_0000, 5'd4,  32'h4000_0000, 1);
        do_op("mulhu",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5,  32'hFFFF_FFFE, 1);
        do_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFF, 1);
        do_op("div",    3'd4, 32'hFFFF_FFEC, 32'd3,         5'd7,  32'hFFFF_FFFA, 32);
        do_op("rem",    3'd6, 32'hFFFF_FFEC, 32'd3,         5'd8,  32'hFFFF_FFFE, 32);
        do_op("divu",   3'd5, 32'd100,       32'd7,         5'd9,  32'd14,        32);
        do_op("remu",   3'd7, 32'd100,       32'd7,         5'd10, 32'd2,         32);
        do_op("div0",   3'd4, 32'd5,         32'd0,         5'd11, 32'hFFFF_FFFF, 1);
        do_op("remu0",  3'd7, 32'd5,         32'd0,         5'd12, 32'd5,         1);
        do_op("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000, 1);
        do_op("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'd0,         1);

        // start during a divide is ignored
        @(negedge clk);
        send(3'd5, 32'd1000, 32'd10, 5'd15);
        repeat (5) @(posedge clk);
        #1;
        bus.start = 1'b1; bus.funct3 = 3'd0; bus.op_a = 32'd2; bus.op_b = 32'd2; bus.rd_in = 5'd1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done("ignore", 26, 32'd100, 5'd15);

        // flush at divide cycle 10: no done, result kept
        @(negedge clk);
        send(3'd5, 32'd77, 32'd5, 5'd16);
        repeat (9) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        check("flush.busy", 32'(bus.busy), 32'd0);
        flag = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.done) flag = 1'b1;
        end
        check("flush.no_done", 32'(flag), 32'd0);
        check("flush.result_kept", bus.result, 32'd100);
        check("flush.rd_kept", 32'(bus.rd_out), 32'd15);
        do_op("after_flush", 3'd0, 32'd2, 32'd3, 5'd17, 32'd6, 1);

        // asynchronous reset mid-divide
        @(negedge clk);
        send(3'd4, 32'd500, 32'd3, 5'd18);
        repeat (20) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid.busy", 32'(bus.busy), 32'd0);
        check("rst_mid.done", 32'(bus.done), 32'd0);
        check("rst_mid.result", bus.result, 32'd0);
        check("rst_mid.rd_out", 32'(bus.rd_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op("post_rst", 3'd5, 32'd9, 32'd2, 5'd19, 32'd4, 32);

        // back-to-back: MUL issued in the DONE cycle of a DIV
        @(negedge clk);
        send(3'd4, 32'd100, 32'd7, 5'd20);
        wait_done("b2b_div", 32, 32'd14, 5'd20);
        send(3'd0, 32'd3, 32'd4, 5'd21);
        check("b2b.no_bubble", 32'(bus.busy), 32'd1);
        wait_done("b2b_mul", 1, 32'd12, 5'd21);

        // randomized ops against the reference model
        for (int i = 0; i < 40; i++) begin
            rf = 3'($urandom);
            ra = $urandom;
            rb = $urandom;
            rt = 5'($urandom);
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 15));
                3: ra = ra >> $urandom_range(0, 31);
                default: ;
            endcase
            last_res = model(rf, ra, rb);
            do_op($sformatf("rand%0d_f%0d", i, rf), rf, ra, rb, rt, last_res,
                  model_lat(rf, ra, rb));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Multi-cycle RV32M execute unit: takes the two source operands read from the register file plus the decoded M-extension funct3 and produces the 32-bit result destined for the register-file write port. Multiplies complete in one cycle after acceptance; divides and remainders use a 32-iteration restoring divider. A start/busy/done handshake lets the core stall while a division is in flight. The completion tag `rd_out` is returned with the result.

## Interface
- No parameters (XLEN fixed at 32).
- `clk`  in  1  system clock, rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only when `busy`=0.
- `flush`  in  1  synchronous abort of any in-flight op.
- `funct3`  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `op_a`  in  32  rs1 value (multiplicand / dividend).
- `op_b`  in  32  rs2 value (multiplier / divisor).
- `rd_in`  in  5  destination register tag.
- `busy`  out  1  op in flight; `start` ignored.
- `done`  out  1  one-cycle pulse: `result`/`rd_out` valid.
- `result`  out  32  final result; held until next completion.
- `rd_out`  out  5  tag latched at acceptance.

## Operation
- States: IDLE, EXEC (multiply or special-case divide), DIV (iterating), DONE.
- Accept: rising edge with `start`=1, `busy`=0, `flush`=0 (state IDLE or DONE). Latch `funct3`, operands, `rd_in`.
- Accept → EXEC if funct3[2]=0, or if divisor = 0, or if signed overflow (DIV/REM, `op_a`=0x80000000, `op_b`=0xFFFFFFFF); otherwise → DIV with iteration counter = 0.
- EXEC: compute the 64-bit product with signedness from funct3: MUL/MULH signed×signed, MULHSU signed `op_a` × unsigned `op_b`, MULHU unsigned×unsigned. MUL returns bits [31:0]; the others return [63:32]. Special cases: divide by zero gives DIV/DIVU = 0xFFFFFFFF and REM/REMU = `op_a`. Overflow gives DIV = 0x80000000 and REM = 0. Go to DONE.
- DIV: signed ops first convert operands to magnitudes. Each cycle does one restoring step: shift the remainder left and bring in the next dividend bit; subtract the divisor if the result is non-negative; shift the quotient bit in. After iteration 31 apply the signs: quotient is negated if sign_a ^ sign_b; remainder takes the sign of `op_a`. Load `result`, then go to DONE.
- DONE: `done`=1 for exactly this cycle. Next state is IDLE, or EXEC/DIV if a new op is accepted on this edge.
- `busy` = state ∈ {EXEC, DIV}.
- `flush`=1 on any edge: state → IDLE with no `done` and `result`/`rd_out` unchanged. It also blocks a same-edge accept.
- `start` while `busy`=1 is ignored entirely and is not queued.

## Timing
- Reset (async assert, any time): state IDLE, `busy`=0, `done`=0, `result`=0, `rd_out`=0, divider registers 0. An in-flight op is discarded.
- Let T be the accept edge.
  - `busy`=1 from T until the edge that enters DONE.
  - MUL family and divide special cases: DONE entered at edge T+1, so `done` is high between T+1 and T+2.
  - Normal divide: iterations occur on edges T+1..T+32; DONE entered at edge T+32, so `done` is high between T+32 and T+33.
- Back-to-back: `start` during the DONE cycle is accepted at that edge, giving zero bubble.
- Inputs need only be valid in the accept cycle. Later changes to `op_a`, `op_b`, `funct3` or `rd_in` have no effect.
- All arithmetic is modulo 2^32 on outputs. The divider's internal remainder is 33 bits to hold the subtraction sign.

## Test plan
- Multiply (each expected `done` exactly 1 cycle after accept):
  - MUL 7×0xFFFFFFFD → 0xFFFFFFEB.
  - MULH 0x80000000×0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
  - `rd_out` must equal the tag given at accept.
- Divide (each expected `done` exactly 32 cycles after accept, with `busy`=1 throughout):
  - DIV 0xFFFFFFEC/3 → 0xFFFFFFFA.
  - REM 0xFFFFFFEC/3 → 0xFFFFFFFE.
  - DIVU 100/7 → 14.
  - REMU 100/7 → 2.
- Special cases (each expected `done` 1 cycle after accept):
  - DIV 5/0 → 0xFFFFFFFF.
  - REMU 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM of the same operands → 0.
- Busy and flush:
  - Pulse `start` with a different op at divide cycle 5 → ignored; the original result is delivered.
  - `flush` at divide cycle 10 → IDLE, no `done` pulse, `result` keeps its prior value; a following MUL completes normally.
- Reset mid-op: drop `rst_n` at divide cycle 20 → `busy`, `done`, `result` and `rd_out` go to 0 immediately with no clock edge. After release, DIVU 9/2 → 4.
- Back-to-back: assert `start` (MUL 3×4) in the DONE cycle of a DIV → accepted with no idle cycle; `done` with `result` 12 follows one cycle later.
